// File: rtl/pll_reset_sequencer_if.sv
// Handshake bundle between the PLL lock/soft-reset sources and the sequencer.
// Outputs feed every clk_sys consumer in the core.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       soft_reset;
    logic       sys_rst_n;
    logic       ce_cpu;
    logic       ce_psg;
    logic [1:0] seq_state;
    logic [7:0] lock_loss_cnt;

    modport master (
        input  pll_locked,
        input  soft_reset,
        output sys_rst_n,
        output ce_cpu,
        output ce_psg,
        output seq_state,
        output lock_loss_cnt
    );

    modport slave (
        output pll_locked,
        output soft_reset,
        input  sys_rst_n,
        input  ce_cpu,
        input  ce_psg,
        input  seq_state,
        input  lock_loss_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL-lock driven reset sequencer for the 20 MHz system domain.
// Produces a registered core reset and CPU/PSG clock enables.
module pll_reset_sequencer #(
    parameter int LOCK_WAIT = 1024,
    parameter int RST_HOLD  = 64,
    parameter int CPU_DIV   = 5,
    parameter int PSG_DIV   = 20
) (
    input logic                   clk_sys,
    input logic                   reset_n,
    pll_reset_sequencer_if.master bus
);

    if (LOCK_WAIT < 1 || LOCK_WAIT > 2048) begin : g_bad_lock_wait
        $error("pll_reset_sequencer: LOCK_WAIT out of range");
    end
    if (RST_HOLD < 1 || RST_HOLD > 2048) begin : g_bad_rst_hold
        $error("pll_reset_sequencer: RST_HOLD out of range");
    end
    if (CPU_DIV < 2) begin : g_bad_cpu_div
        $error("pll_reset_sequencer: CPU_DIV out of range");
    end
    if (PSG_DIV < 2) begin : g_bad_psg_div
        $error("pll_reset_sequencer: PSG_DIV out of range");
    end

    localparam int CW = $clog2(CPU_DIV);
    localparam int PW = $clog2(PSG_DIV);
    localparam logic [10:0]   LW_LAST  = 11'(LOCK_WAIT - 1);
    localparam logic [10:0]   RH_LAST  = 11'(RST_HOLD - 1);
    localparam logic [CW-1:0] CPU_LAST = CW'(CPU_DIV - 1);
    localparam logic [PW-1:0] PSG_LAST = PW'(PSG_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        STABILIZE = 2'b01,
        HOLD      = 2'b10,
        RUN       = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    sync_q;
    logic [10:0]   cnt_q, cnt_d;
    logic [7:0]    loss_q, loss_d;
    logic [CW-1:0] cpu_q, cpu_d;
    logic [PW-1:0] psg_q, psg_d;
    logic          sys_rst_n_q, ce_cpu_q, ce_psg_q;
    logic [1:0]    seq_state_q;
    logic          locked_s;
    logic          in_run_d;

    assign locked_s = sync_q[1];

    // Lock loss outranks soft reset, which outranks count expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) state_d = STABILIZE;
            end
            STABILIZE: begin
                if (!locked_s)             state_d = WAIT_LOCK;
                else if (cnt_q == LW_LAST) state_d = HOLD;
                else                       cnt_d = cnt_q + 11'd1;
            end
            HOLD: begin
                if (!locked_s)                 state_d = WAIT_LOCK;
                else if (bus.soft_reset)       cnt_d = '0;
                else if (cnt_q == RH_LAST)     state_d = RUN;
                else                           cnt_d = cnt_q + 11'd1;
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (bus.soft_reset) begin
                    state_d = HOLD;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Dividers only advance across consecutive RUN cycles, so a fresh
    // RUN entry always starts a full period and no pulse is ever clipped.
    assign in_run_d = (state_q == RUN) && (state_d == RUN);

    always_comb begin
        cpu_d = '0;
        psg_d = '0;
        if (in_run_d) begin
            cpu_d = (cpu_q == CPU_LAST) ? '0 : cpu_q + CW'(1);
            psg_d = (psg_q == PSG_LAST) ? '0 : psg_q + PW'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_LOCK;
            sync_q      <= '0;
            cnt_q       <= '0;
            loss_q      <= '0;
            cpu_q       <= '0;
            psg_q       <= '0;
            sys_rst_n_q <= 1'b0;
            ce_cpu_q    <= 1'b0;
            ce_psg_q    <= 1'b0;
            seq_state_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], bus.pll_locked};
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            cpu_q       <= cpu_d;
            psg_q       <= psg_d;
            sys_rst_n_q <= (state_d == RUN);
            ce_cpu_q    <= (state_d == RUN) && (cpu_d == CPU_LAST);
            ce_psg_q    <= (state_d == RUN) && (psg_d == PSG_LAST);
            seq_state_q <= state_d;
        end
    end

    assign bus.sys_rst_n     = sys_rst_n_q;
    assign bus.ce_cpu        = ce_cpu_q;
    assign bus.ce_psg        = ce_psg_q;
    assign bus.seq_state     = seq_state_q;
    assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed and randomized bench for pll_reset_sequencer against a
// cycle-count reference model.
module tb_pll_reset_sequencer;

    localparam int LW = 8;
    localparam int RH = 4;
    localparam int CD = 5;
    localparam int PD = 20;
    localparam int LAT = 3 + LW + RH;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .LOCK_WAIT(LW),
        .RST_HOLD (RH),
        .CPU_DIV  (CD),
        .PSG_DIV  (PD)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int passed = 0;
    int total  = 0;

    // Reference model: phase 0..3, cycles spent in phase, RUN cycle index.
    int m_phase, m_spent, m_run, m_loss;
    bit m_s1, m_s2;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_phase = 0; m_spent = 0; m_run = 0; m_loss = 0;
        m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_edge();
        bit ls;
        ls = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.pll_locked;
        if (!reset_n) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: if (ls) begin m_phase = 1; m_spent = 0; end
            1: if (!ls) m_phase = 0;
               else begin
                   m_spent++;
                   if (m_spent == LW) begin m_phase = 2; m_spent = 0; end
               end
            2: if (!ls) m_phase = 0;
               else if (bus.soft_reset) m_spent = 0;
               else begin
                   m_spent++;
                   if (m_spent == RH) begin m_phase = 3; m_run = 1; end
               end
            default:
               if (!ls) begin
                   m_phase = 0;
                   if (m_loss < 255) m_loss++;
               end else if (bus.soft_reset) begin
                   m_phase = 2; m_spent = 0;
               end else m_run++;
        endcase
    endtask

    function automatic logic [12:0] model_out();
        logic r, c, p;
        r = (m_phase == 3);
        c = r && (m_run % CD == 0);
        p = r && (m_run % PD == 0);
        return {r, c, p, 2'(m_phase), 8'(m_loss)};
    endfunction

    function automatic logic [12:0] dut_out();
        return {bus.sys_rst_n, bus.ce_cpu, bus.ce_psg,
                bus.seq_state, bus.lock_loss_cnt};
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        model_edge();
        #1;
        chk("model", 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (!bus.sys_rst_n && n < 200) begin
            tick();
            n++;
        end
    endtask

    int n, nc, np;

    initial begin
        model_reset();
        bus.pll_locked = 1'b1;
        bus.soft_reset = 1'b0;

        // 1: reset state, then release latency
        repeat (3) tick();
        chk("reset_outs", 32'(dut_out()), 32'd0);
        reset_n = 1'b1;
        wait_run(n);
        chk("release_lat", 32'(n), 32'(LAT));
        chk("state_run", 32'(bus.seq_state), 32'd3);

        // 2: enable pulse counts over 100 RUN cycles
        nc = int'(bus.ce_cpu);
        np = int'(bus.ce_psg);
        repeat (99) begin
            tick();
            nc += int'(bus.ce_cpu);
            np += int'(bus.ce_psg);
        end
        chk("ce_cpu_cnt", 32'(nc), 32'd20);
        chk("ce_psg_cnt", 32'(np), 32'd5);

        // 3: short lock loss from RUN
        bus.pll_locked = 1'b0;
        repeat (3) tick();
        chk("loss_rst", 32'(bus.sys_rst_n), 32'd0);
        chk("loss_cnt1", 32'(bus.lock_loss_cnt), 32'd1);
        bus.pll_locked = 1'b1;
        wait_run(n);
        chk("relock_lat", 32'(n), 32'(LAT));

        // 4: soft reset for 10 cycles
        bus.soft_reset = 1'b1;
        repeat (10) tick();
        chk("soft_hold", 32'(bus.seq_state), 32'd2);
        bus.soft_reset = 1'b0;
        wait_run(n);
        chk("soft_lat", 32'(n + 10), 32'(10 + RH));
        chk("soft_loss", 32'(bus.lock_loss_cnt), 32'd1);

        // 5: coincident lock loss and soft reset at the DUT
        bus.pll_locked = 1'b0;
        repeat (2) tick();
        bus.soft_reset = 1'b1;
        tick();
        chk("prio_state", 32'(bus.seq_state), 32'd0);
        chk("prio_loss", 32'(bus.lock_loss_cnt), 32'd2);
        bus.soft_reset = 1'b0;
        bus.pll_locked = 1'b1;
        wait_run(n);
        repeat (300) begin
            bus.pll_locked = 1'b0;
            repeat (3) tick();
            bus.pll_locked = 1'b1;
            wait_run(n);
        end
        chk("loss_sat", 32'(bus.lock_loss_cnt), 32'd255);

        // 6: async reset mid-STABILIZE
        reset_n = 1'b0;
        #1;
        model_reset();
        tick();
        reset_n = 1'b1;
        repeat (3 + 5) tick();
        chk("mid_stab", 32'(bus.seq_state), 32'd1);
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst", 32'(dut_out()), 32'd0);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        wait_run(n);
        chk("restart_lat", 32'(n), 32'(LAT));

        // Randomized lock drops and soft resets
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0)
                bus.pll_locked = ~bus.pll_locked;
            else if (!bus.pll_locked && $urandom_range(0, 3) == 0)
                bus.pll_locked = 1'b1;
            if ($urandom_range(0, 29) == 0)
                bus.soft_reset = ~bus.soft_reset;
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
